// File: rtl/udp_pkg.sv
// udp_pkg: shared constants, egress state encoding and ones'-complement adder
// for the UDP/IPv4/Ethernet transmit framer.
package udp_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam int unsigned HDR_WORDS      = 21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_DROP
  } udp_state_t;

  // 16-bit ones'-complement add: carry out of bit 15 wraps into bit 0.
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/udp_sync_fifo.sv
// udp_sync_fifo: single-clock show-ahead FIFO.
//   wr_en/wr_data : write port (ignored when full)
//   rd_en/rd_data : rd_data shows the head word; rd_en pops it (ignored when empty)
//   empty/full    : status flags
//   used          : number of stored words
module udp_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   used
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign used    = wr_ptr - rd_ptr;
  assign empty   = (used == '0);
  assign full    = (used == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: store-and-forward UDP/IPv4/Ethernet transmit framer.
// Buffers whole packets, then emits a 21-word header followed by the payload.
//   clk, rst_n                      : clock, async active-low reset
//   cfg_mac_d/s, cfg_sip/dip,
//   cfg_sport/dport                 : static header fields
//   s_data/s_sop/s_eop/s_mty/s_vld  : application input stream, s_rdy registered
//   m_data/m_sop/m_eop/m_mty/m_vld  : framed output stream, m_rdy backpressure
// Macro UDP_CSUM_EN: when defined the UDP checksum is computed; otherwise
// header word 20 is zero and the ingress payload sum is not built.
module udp_tx_framer #(
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned META_DEPTH = 16,
  parameter int unsigned MAX_BYTES  = 1472,
  parameter int unsigned IP_TTL     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] cfg_mac_d,
  input  logic [47:0] cfg_mac_s,
  input  logic [31:0] cfg_sip,
  input  logic [31:0] cfg_dip,
  input  logic [15:0] cfg_sport,
  input  logic [15:0] cfg_dport,
  input  logic [15:0] s_data,
  input  logic        s_sop,
  input  logic        s_eop,
  input  logic        s_mty,
  input  logic        s_vld,
  output logic        s_rdy,
  output logic [15:0] m_data,
  output logic        m_sop,
  output logic        m_eop,
  output logic        m_mty,
  output logic        m_vld,
  input  logic        m_rdy
);

  import udp_pkg::*;

  localparam int unsigned PCW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned MCW = $clog2(META_DEPTH) + 1;

  // ---------------- ingress ----------------
  logic            in_pkt;
  logic [15:0]     acc_bytes;
  logic            take, odd;
  logic [15:0]     new_bytes, new_sum;
  logic            pay_wr, meta_wr;
  logic [17:0]     pay_wdata, pay_rdata;
  logic [32:0]     meta_wdata, meta_rdata;
  logic            pay_rd, meta_rd;
  logic            pay_empty, pay_full, meta_empty, meta_full;
  logic [PCW-1:0]  pay_used;
  logic [MCW-1:0]  meta_used;

`ifdef UDP_CSUM_EN
  logic [15:0] acc_sum;
  logic [15:0] sum_word;
`endif

  always_comb begin
    take      = s_vld && s_rdy && (in_pkt || s_sop);
    odd       = s_eop && s_mty;
    new_bytes = (in_pkt ? acc_bytes : 16'd0) + (odd ? 16'd1 : 16'd2);
`ifdef UDP_CSUM_EN
    sum_word  = odd ? {s_data[15:8], 8'h00} : s_data;
    new_sum   = csum_add(in_pkt ? acc_sum : 16'd0, sum_word);
`else
    new_sum   = '0;
`endif
    pay_wr     = take;
    pay_wdata  = {s_eop, odd, s_data};
    meta_wr    = take && s_eop;
    meta_wdata = {(32'(new_bytes) > MAX_BYTES), new_bytes, new_sum};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt    <= 1'b0;
      acc_bytes <= '0;
`ifdef UDP_CSUM_EN
      acc_sum   <= '0;
`endif
      s_rdy     <= 1'b0;
    end else begin
      if (take) begin
        in_pkt    <= !s_eop;
        acc_bytes <= new_bytes;
`ifdef UDP_CSUM_EN
        acc_sum   <= new_sum;
`endif
      end
      // Occupancy after this cycle's write; same-cycle pops only delay re-assertion.
      s_rdy <= (32'(pay_used) + 32'(pay_wr) + 32'd4 <= FIFO_DEPTH) &&
               (32'(meta_used) + 32'(meta_wr) < META_DEPTH);
    end
  end

  udp_sync_fifo #(.WIDTH(18), .DEPTH(FIFO_DEPTH)) u_pay_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pay_wr),
    .wr_data (pay_wdata),
    .rd_en   (pay_rd),
    .rd_data (pay_rdata),
    .empty   (pay_empty),
    .full    (pay_full),
    .used    (pay_used)
  );

  udp_sync_fifo #(.WIDTH(33), .DEPTH(META_DEPTH)) u_meta_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (meta_wr),
    .wr_data (meta_wdata),
    .rd_en   (meta_rd),
    .rd_data (meta_rdata),
    .empty   (meta_empty),
    .full    (meta_full),
    .used    (meta_used)
  );

  // ---------------- egress ----------------
  udp_state_t  state, state_nx;
  logic [4:0]  hdr_cnt, cnt_nx;
  logic [15:0] reg_bytes, ip_id;
  logic [15:0] ip_len, udp_len, ip_acc, ip_chk, udp_chk, hdr_word;
  logic        adv, dispatch, id_inc;
  logic        ld, ld_vld, ld_sop, ld_eop, ld_mty;
  logic [15:0] ld_data;

`ifdef UDP_CSUM_EN
  logic [15:0] reg_sum, udp_acc;
`endif

  logic unused_ok;
`ifdef UDP_CSUM_EN
  assign unused_ok = pay_full ^ meta_full;
`else
  assign unused_ok = pay_full ^ meta_full ^ (^meta_rdata[15:0]);
`endif

  always_comb begin
    ip_len  = reg_bytes + 16'd28;
    udp_len = reg_bytes + 16'd8;
    ip_acc  = csum_add(16'h4500, ip_len);
    ip_acc  = csum_add(ip_acc, ip_id);
    ip_acc  = csum_add(ip_acc, {8'(IP_TTL), IP_PROTO_UDP});
    ip_acc  = csum_add(ip_acc, cfg_sip[31:16]);
    ip_acc  = csum_add(ip_acc, cfg_sip[15:0]);
    ip_acc  = csum_add(ip_acc, cfg_dip[31:16]);
    ip_acc  = csum_add(ip_acc, cfg_dip[15:0]);
    ip_chk  = ~ip_acc;
`ifdef UDP_CSUM_EN
    udp_acc = csum_add(cfg_sip[31:16], cfg_sip[15:0]);
    udp_acc = csum_add(udp_acc, cfg_dip[31:16]);
    udp_acc = csum_add(udp_acc, cfg_dip[15:0]);
    udp_acc = csum_add(udp_acc, {8'h00, IP_PROTO_UDP});
    udp_acc = csum_add(udp_acc, udp_len);
    udp_acc = csum_add(udp_acc, cfg_sport);
    udp_acc = csum_add(udp_acc, cfg_dport);
    udp_acc = csum_add(udp_acc, udp_len);
    udp_acc = csum_add(udp_acc, reg_sum);
    udp_chk = (udp_acc == 16'hFFFF) ? 16'hFFFF : ~udp_acc;
`else
    udp_chk = '0;
`endif
  end

  always_comb begin
    hdr_word = '0;
    case (hdr_cnt)
      5'd0:  hdr_word = cfg_mac_d[47:32];
      5'd1:  hdr_word = cfg_mac_d[31:16];
      5'd2:  hdr_word = cfg_mac_d[15:0];
      5'd3:  hdr_word = cfg_mac_s[47:32];
      5'd4:  hdr_word = cfg_mac_s[31:16];
      5'd5:  hdr_word = cfg_mac_s[15:0];
      5'd6:  hdr_word = ETHERTYPE_IPV4;
      5'd7:  hdr_word = 16'h4500;
      5'd8:  hdr_word = ip_len;
      5'd9:  hdr_word = ip_id;
      5'd10: hdr_word = 16'h0000;
      5'd11: hdr_word = {8'(IP_TTL), IP_PROTO_UDP};
      5'd12: hdr_word = ip_chk;
      5'd13: hdr_word = cfg_sip[31:16];
      5'd14: hdr_word = cfg_sip[15:0];
      5'd15: hdr_word = cfg_dip[31:16];
      5'd16: hdr_word = cfg_dip[15:0];
      5'd17: hdr_word = cfg_sport;
      5'd18: hdr_word = cfg_dport;
      5'd19: hdr_word = udp_len;
      5'd20: hdr_word = udp_chk;
      default: hdr_word = '0;
    endcase
  end

  always_comb begin
    adv      = !m_vld || m_rdy;
    state_nx = state;
    cnt_nx   = hdr_cnt;
    dispatch = 1'b0;
    id_inc   = 1'b0;
    meta_rd  = 1'b0;
    pay_rd   = 1'b0;
    ld       = 1'b0;
    ld_vld   = 1'b0;
    ld_sop   = 1'b0;
    ld_eop   = 1'b0;
    ld_mty   = 1'b0;
    ld_data  = '0;
    case (state)
      ST_IDLE: begin
        dispatch = 1'b1;
        ld       = adv;
      end
      ST_HDR: begin
        if (adv) begin
          ld      = 1'b1;
          ld_vld  = 1'b1;
          ld_data = hdr_word;
          ld_sop  = (hdr_cnt == 5'd0);
          if (hdr_cnt == 5'(HDR_WORDS - 1)) begin
            state_nx = ST_PAY;
            cnt_nx   = '0;
          end else begin
            cnt_nx = hdr_cnt + 5'd1;
          end
        end
      end
      ST_PAY: begin
        if (adv) begin
          ld = 1'b1;
          if (!pay_empty) begin
            pay_rd  = 1'b1;
            ld_vld  = 1'b1;
            ld_data = pay_rdata[15:0];
            ld_mty  = pay_rdata[16];
            ld_eop  = pay_rdata[17];
            if (pay_rdata[17]) begin
              id_inc   = 1'b1;
              dispatch = 1'b1;
            end
          end
        end
      end
      ST_DROP: begin
        ld = adv;
        if (!pay_empty) begin
          pay_rd = 1'b1;
          if (pay_rdata[17])
            dispatch = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Leaving a packet picks up the next one directly so back-to-back packets
    // stream without an idle cycle in between.
    if (dispatch) begin
      cnt_nx = '0;
      if (!meta_empty) begin
        meta_rd  = 1'b1;
        state_nx = meta_rdata[32] ? ST_DROP : ST_HDR;
      end else begin
        state_nx = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hdr_cnt   <= '0;
      reg_bytes <= '0;
`ifdef UDP_CSUM_EN
      reg_sum   <= '0;
`endif
      ip_id     <= '0;
      m_data    <= '0;
      m_sop     <= 1'b0;
      m_eop     <= 1'b0;
      m_mty     <= 1'b0;
      m_vld     <= 1'b0;
    end else begin
      state   <= state_nx;
      hdr_cnt <= cnt_nx;
      if (meta_rd) begin
        reg_bytes <= meta_rdata[31:16];
`ifdef UDP_CSUM_EN
        reg_sum   <= meta_rdata[15:0];
`endif
      end
      if (id_inc)
        ip_id <= ip_id + 16'd1;
      if (ld) begin
        m_data <= ld_data;
        m_sop  <= ld_sop;
        m_eop  <= ld_eop;
        m_mty  <= ld_mty;
        m_vld  <= ld_vld;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_framer.sv
module tb_udp_tx_framer;

  localparam int unsigned FD = 1024;
  localparam logic [47:0] MAC_D = 48'h0011_2233_4455;
  localparam logic [47:0] MAC_S = 48'h6677_8899_AABB;
  localparam logic [31:0] SIP   = 32'hC0A8_0001;
  localparam logic [31:0] DIP   = 32'hC0A8_0002;
  localparam logic [15:0] SPORT = 16'h1234;
  localparam logic [15:0] DPORT = 16'h5678;
  localparam logic [15:0] TTLPROTO = 16'h4011;

`ifdef UDP_CSUM_EN
  localparam logic [15:0] T1_UDP = 16'h11D0;
`else
  localparam logic [15:0] T1_UDP = 16'h0000;
`endif
  localparam logic [15:0] T1_HDR [21] = '{
    16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB, 16'h0800,
    16'h4500, 16'h0020, 16'h0000, 16'h0000, 16'h4011, 16'hF979,
    16'hC0A8, 16'h0001, 16'hC0A8, 16'h0002,
    16'h1234, 16'h5678, 16'h000C, T1_UDP };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_sop = 1'b0, s_eop = 1'b0, s_mty = 1'b0, s_vld = 1'b0;
  logic        s_rdy;
  logic [15:0] m_data;
  logic        m_sop, m_eop, m_mty, m_vld;
  logic        m_rdy = 1'b0;

  always #5 clk = ~clk;

  udp_tx_framer #(
    .FIFO_DEPTH (FD),
    .META_DEPTH (16),
    .MAX_BYTES  (1472),
    .IP_TTL     (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_mac_d (MAC_D),
    .cfg_mac_s (MAC_S),
    .cfg_sip   (SIP),
    .cfg_dip   (DIP),
    .cfg_sport (SPORT),
    .cfg_dport (DPORT),
    .s_data    (s_data),
    .s_sop     (s_sop),
    .s_eop     (s_eop),
    .s_mty     (s_mty),
    .s_vld     (s_vld),
    .s_rdy     (s_rdy),
    .m_data    (m_data),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .m_mty     (m_mty),
    .m_vld     (m_vld),
    .m_rdy     (m_rdy)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        sop;
    logic        eop;
    logic        mty;
  } ow_t;

  ow_t         exp_q[$];
  logic [15:0] pw[$];
  logic [15:0] tb_id = '0;
  int unsigned n_pass = 0, n_tot = 0;
  int unsigned acc_words = 0;
  int unsigned rdy_mode = 0;   // 0: m_rdy low, 1: high, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Downstream ready driver, applied 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: m_rdy = 1'b0;
        1: m_rdy = 1'b1;
        default: m_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every presented word must equal the scoreboard head, stalled or not.
  always @(negedge clk) begin
    ow_t got;
    if (rst_n && m_vld) begin
      got = {m_data, m_sop, m_eop, m_mty};
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_word: got %0h expected no output", got);
      end else begin
        chk(m_rdy ? "out_word" : "out_hold", 64'(got), 64'(exp_q[0]));
        if (m_rdy) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] fold(input logic [31:0] v);
    while (v[31:16] != 16'h0) v = {16'h0, v[15:0]} + {16'h0, v[31:16]};
    return v[15:0];
  endfunction

  task automatic push_w(input logic [15:0] d, input logic sop, input logic eop, input logic mty);
    exp_q.push_back(ow_t'({d, sop, eop, mty}));
  endtask

  task automatic push_pay(input bit odd);
    for (int i = 0; i < pw.size(); i++)
      push_w(pw[i], 1'b0, i == pw.size() - 1, odd && (i == pw.size() - 1));
  endtask

  // Reference header model: 32-bit accumulation then carry fold.
  task automatic push_exp(input bit odd);
    int unsigned nw;
    logic [15:0] bytes, ipl, udl, ipc, udc;
    logic [31:0] s, ps;
    nw    = pw.size();
    bytes = 16'(2 * nw - (odd ? 1 : 0));
    ipl   = bytes + 16'd28;
    udl   = bytes + 16'd8;
    s     = 32'h4500 + ipl + tb_id + TTLPROTO + SIP[31:16] + SIP[15:0] + DIP[31:16] + DIP[15:0];
    ipc   = ~fold(s);
    ps    = '0;
    for (int i = 0; i < nw; i++)
      ps += (odd && i == nw - 1) ? {pw[i][15:8], 8'h00} : pw[i];
`ifdef UDP_CSUM_EN
    s   = SIP[31:16] + SIP[15:0] + DIP[31:16] + DIP[15:0] + 32'h11 + udl + SPORT + DPORT + udl + ps;
    udc = ~fold(s);
    if (udc == 16'h0) udc = 16'hFFFF;
`else
    udc = 16'h0;
`endif
    push_w(MAC_D[47:32], 1'b1, 1'b0, 1'b0);
    push_w(MAC_D[31:16], 1'b0, 1'b0, 1'b0);
    push_w(MAC_D[15:0],  1'b0, 1'b0, 1'b0);
    push_w(MAC_S[47:32], 1'b0, 1'b0, 1'b0);
    push_w(MAC_S[31:16], 1'b0, 1'b0, 1'b0);
    push_w(MAC_S[15:0],  1'b0, 1'b0, 1'b0);
    push_w(16'h0800, 1'b0, 1'b0, 1'b0);
    push_w(16'h4500, 1'b0, 1'b0, 1'b0);
    push_w(ipl,      1'b0, 1'b0, 1'b0);
    push_w(tb_id,    1'b0, 1'b0, 1'b0);
    push_w(16'h0000, 1'b0, 1'b0, 1'b0);
    push_w(TTLPROTO, 1'b0, 1'b0, 1'b0);
    push_w(ipc,      1'b0, 1'b0, 1'b0);
    push_w(SIP[31:16], 1'b0, 1'b0, 1'b0);
    push_w(SIP[15:0],  1'b0, 1'b0, 1'b0);
    push_w(DIP[31:16], 1'b0, 1'b0, 1'b0);
    push_w(DIP[15:0],  1'b0, 1'b0, 1'b0);
    push_w(SPORT, 1'b0, 1'b0, 1'b0);
    push_w(DPORT, 1'b0, 1'b0, 1'b0);
    push_w(udl,   1'b0, 1'b0, 1'b0);
    push_w(udc,   1'b0, 1'b0, 1'b0);
    push_pay(odd);
    tb_id = tb_id + 16'd1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic put_word(input logic [15:0] d, input logic sop, input logic eop, input logic mty);
    int unsigned n;
    n = 0;
    s_data = d; s_sop = sop; s_eop = eop; s_mty = mty; s_vld = 1'b1;
    while (!s_rdy && n < 20000) begin
      @(posedge clk); #1; n++;
    end
    if (!s_rdy) begin
      n_tot++;
      $display("FAIL s_rdy_timeout: s_rdy %0d required 1", s_rdy);
    end else begin
      @(posedge clk); #1;
      acc_words++;
    end
    s_vld = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_mty = 1'b0;
  endtask

  task automatic send(input bit odd, input bit expect_out);
    if (expect_out) push_exp(odd);
    for (int i = 0; i < pw.size(); i++)
      put_word(pw[i], i == 0, i == pw.size() - 1, odd && (i == pw.size() - 1));
  endtask

  task automatic fill_pw(input int unsigned n, input logic [7:0] tag);
    pw.delete();
    for (int unsigned i = 0; i < n; i++) pw.push_back({tag, 8'(i)});
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    s_vld = 1'b0;
    exp_q.delete();
    tb_id = '0;
    @(negedge clk);
    chk("reset_outputs", 64'({m_data, m_sop, m_eop, m_mty, m_vld, s_rdy}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned n;

    do_reset();
    rdy_mode = 1;

    // Hand-computed 4-byte packet, plus store-and-forward latency.
    for (int i = 0; i < 21; i++) push_w(T1_HDR[i], i == 0, 1'b0, 1'b0);
    push_w(16'h0102, 1'b0, 1'b0, 1'b0);
    push_w(16'h0304, 1'b0, 1'b1, 1'b0);
    tb_id = 16'd1;
    put_word(16'h0102, 1'b1, 1'b0, 1'b0);
    put_word(16'h0304, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!m_vld && n < 100) begin @(posedge clk); #1; n++; end
    n_tot++;
    if (n >= 2 && n < 100) n_pass++;
    else $display("FAIL sf_latency: got %0d cycles required >= 2", n);
    wait_drain("drain_t1");

    // Stray word outside a packet is discarded; odd-length packet follows.
    put_word(16'hDEAD, 1'b0, 1'b0, 1'b0);
    pw = '{16'h0102, 16'h03AA};
    send(1'b1, 1'b1);
    wait_drain("drain_odd");

    // Oversize drop, then ip_id still 0; then exactly MAX_BYTES passes.
    do_reset();
    rdy_mode = 1;
    fill_pw(737, 8'hD0);
    send(1'b0, 1'b0);
    pw = '{16'hA1A2, 16'hA3A4};
    send(1'b0, 1'b1);
    wait_drain("drain_after_drop");
    fill_pw(736, 8'hB0);
    send(1'b0, 1'b1);
    wait_drain("drain_max_bytes");

    // Random backpressure, including a one-word packet.
    rdy_mode = 2;
    fill_pw(5, 8'h51);
    send(1'b0, 1'b1);
    fill_pw(3, 8'h52);
    send(1'b1, 1'b1);
    pw = '{16'h7788};
    send(1'b0, 1'b1);
    wait_drain("drain_stall");
    rdy_mode = 1;
    repeat (4) @(posedge clk);
    #1;

    // Two buffered packets stream with no bubble: 47 words in 47 cycles.
    rdy_mode = 0;
    fill_pw(3, 8'h61);
    send(1'b0, 1'b1);
    fill_pw(2, 8'h62);
    send(1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rdy_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    chk("no_bubble_cycles", 64'(n), 64'd47);

    // Fill the payload FIFO while stalled: accepts until 3 words remain free.
    rdy_mode = 0;
    acc_words = 0;
    fork
      begin
        for (int p = 0; p < 6; p++) begin
          fill_pw(200, 8'(8'h80 + p));
          send(1'b0, 1'b1);
        end
      end
      begin
        n = 0;
        while (!(s_vld && !s_rdy) && n < 3000) begin @(posedge clk); #1; n++; end
        repeat (4) @(posedge clk);
        #1;
        chk("fill_rdy_low", 64'(s_rdy), 64'd0);
        chk("fill_accepted", 64'(acc_words), 64'(FD - 3));
        rdy_mode = 1;
      end
    join
    wait_drain("drain_fill");

    // Reset with one packet buffered and another half-written.
    rdy_mode = 0;
    fill_pw(4, 8'h91);
    send(1'b0, 1'b1);
    put_word(16'h9201, 1'b1, 1'b0, 1'b0);
    put_word(16'h9202, 1'b0, 1'b0, 1'b0);
    put_word(16'h9203, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    do_reset();
    rdy_mode = 1;
    pw = '{16'hC1C2, 16'hC3C4, 16'hC5C6};
    send(1'b0, 1'b1);
    wait_drain("drain_after_reset");
    repeat (50) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/udp_tx_framer.md
# udp_tx_framer

Parametrised UDP/IPv4/Ethernet transmit framer. It buffers complete application packets, computes byte-accurate IP header and UDP checksums, and emits a 21-word header followed by the payload on a valid/ready stream. It sits between the application TX stream and the MAC TX path. Unlike the previous framer, it adds configurable buffering, correct odd-length handling, hold-under-stall output, and oversize-packet dropping.

## Interface
- FIFO_DEPTH, 1024: payload FIFO depth in 16-bit words, power of two, minimum 64.
- META_DEPTH, 16: metadata FIFO depth in packets, power of two.
- MAX_BYTES, 1472: largest accepted payload in bytes; larger packets are dropped.
- IP_TTL, 64: TTL field value.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_mac_d, cfg_mac_s  in  48  destination and source MAC addresses.
- cfg_sip, cfg_dip  in  32  source and destination IPv4 addresses.
- cfg_sport, cfg_dport  in  16  UDP source and destination ports.
- s_data  in  16  payload word, big-endian (first byte in [15:8]).
- s_sop, s_eop  in  1  first and last word of a packet.
- s_mty  in  1  on the s_eop word: 1 means [7:0] is invalid.
- s_vld  in  1  input word valid.
- s_rdy  out  1  input ready (registered).
- m_data  out  16  output word.
- m_sop, m_eop, m_mty, m_vld  out  1  output framing signals, same meaning as the input side.
- m_rdy  in  1  downstream ready.

## Operation
- An input word is accepted on s_vld & s_rdy. s_vld while s_rdy=0 is a protocol violation and the word is lost.
- s_rdy=1 when payload FIFO free ≥ 4 words and the metadata FIFO is not full.
- Ingress tracks an in-packet flag:
  - Words outside a packet without s_sop are discarded.
  - s_sop inside a packet is treated as ordinary data.
  - A word with both s_sop and s_eop is a one-word packet.
- Per packet, ingress accumulates the byte count (2·words − s_mty) and a ones'-complement payload sum. When s_mty=1, the eop word is summed as {s_data[15:8], 8'h00}. The sum uses end-around carry every word.
- Every word is written to the payload FIFO as {eop, mty, data}.
- On the eop word, the metadata FIFO gets {drop, bytes[15:0], sum[15:0]}. drop = bytes > MAX_BYTES.
- Egress FSM:
  - IDLE → HDR when the metadata FIFO is non-empty. Metadata is registered at entry, and both checksums are computed combinationally from the registered fields. If drop=1, the FSM goes IDLE → DROP instead.
  - HDR emits 21 words → PAY.
  - PAY emits FIFO words until the eop word is sent → IDLE.
  - DROP pops FIFO words without output until eop → IDLE.
- Header word order:
  - 0–2: mac_d; 3–5: mac_s; 6: 0x0800.
  - 7: 0x4500; 8: ip_len = bytes+28; 9: ip_id; 10: 0x0000; 11: {IP_TTL, 8'd17}; 12: ip_chk; 13–14: sip; 15–16: dip.
  - 17: sport; 18: dport; 19: udp_len = bytes+8; 20: udp_chk.
- ip_chk is the one's complement of the ones'-complement sum of header words 7–16, with word 12 taken as 0.
- udp_chk is the one's complement of the sum of: the pseudo-header (sip, dip, 0x0011, udp_len), sport, dport, udp_len, and the payload sum. A computed value of 0x0000 is sent as 0xFFFF.
- ip_id resets to 0 and increments after each transmitted (non-dropped) packet's eop. It wraps 0xFFFF → 0.
- m_sop is set on header word 0 only. m_eop and m_mty are copied from the FIFO eop word. m_mty is 0 on all other words.

## Timing
- All outputs reset to 0: m_data, m_sop, m_eop, m_mty, m_vld, s_rdy. FSM resets to IDLE, ip_id to 0, and both FIFOs are empty. Reset mid-packet discards all buffered data.
- The output register advances when m_vld=0 or m_rdy=1. While m_vld & !m_rdy, every output holds stable.
- Store-and-forward: the first header word appears no earlier than 2 cycles after the input eop is accepted.
- With m_rdy held at 1 and data buffered, output runs one word per cycle with no bubble between header and payload or between back-to-back packets.
- DROP consumes one FIFO word per cycle independently of m_rdy.
- Writing a new packet's metadata and popping the old one in the same cycle is legal.

## Configuration
- UDP_CSUM_EN defined: udp_chk is computed as above.
- UDP_CSUM_EN undefined: word 20 is 0x0000 and the ingress payload-sum logic is removed. The metadata sum field is tied to 0.

## Structure
- Package udp_pkg holds ETHERTYPE_IPV4 (0x0800), IP_PROTO_UDP (17), HDR_WORDS (21), the FSM state enum, and a csum_add function (17-bit add with end-around carry).
- Both FIFOs are instances of a single sub-module, udp_sync_fifo (parametrised width and depth, show-ahead, with used-word count output).

## Test plan
- Configuration: sip 0xC0A80001, dip 0xC0A80002, sport 0x1234, dport 0x5678, TTL 64. Payload 0x0102, 0x0304 (mty=0) → ip_len 0x0020, ip_chk 0xF979, udp_len 0x000C, udp_chk 0x11D0, 23 output words.
- Odd payload 0x0102, 0x03AA with mty=1 → ip_len 31, udp_len 11. Last output word is 0x03AA with m_eop=1, m_mty=1.
- Payload of 737 words (1474 bytes) → no output. The FIFO drains, and the next 4-byte packet goes out with ip_id 0.
- Toggle m_rdy randomly at 50% → m_data and flags stay stable while stalled. Output sequence is identical to the no-stall run.
- Fill the payload FIFO with m_rdy=0 → s_rdy drops at 4 free words. No data is lost and all packets appear in order.
- Assert rst_n low mid-payload, then send one packet → clean output, ip_id 0, no residual words.
